// File: rtl/immgen_pipe_if.sv
// Handshake/data bundle between the instruction register and the immediate pipe.
// The slave modport is the pipe's view; master is the producer/consumer side.
interface immgen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic [31:7]      instr_i;
    logic [2:0]       immsrc_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic [XLEN-1:0]  immext_o;
    logic [TAG_W-1:0] tag_o;
    logic             illegal_o;
    logic             valid_o;
    logic             ready_i;

    modport slave (
        input  instr_i, immsrc_i, tag_i, valid_i, flush_i, ready_i,
        output ready_o, immext_o, tag_o, illegal_o, valid_o
    );

    modport master (
        output instr_i, immsrc_i, tag_i, valid_i, flush_i, ready_i,
        input  ready_o, immext_o, tag_o, illegal_o, valid_o
    );
endinterface

// File: rtl/immgen_pipe.sv
// Pipelined immediate extender: one registered output stage plus one skid entry,
// so ready_o is a pure register and never follows ready_i combinationally.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    immgen_pipe_if.slave bus
);

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_J     = 3'b011;
    localparam logic [2:0] SRC_U     = 3'b100;
    localparam logic [2:0] SRC_Z     = 3'b101;
    localparam logic [2:0] SRC_SHAMT = 3'b110;

    logic [31:0]      w_imm32;
    logic             w_sext;
    logic             w_ill;
    logic [XLEN-1:0]  w_imm;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_ill;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;
    logic             r_ready;

    logic             w_out_valid_next;
    logic [XLEN-1:0]  w_out_imm_next;
    logic [TAG_W-1:0] w_out_tag_next;
    logic             w_out_ill_next;
    logic             w_skid_valid_next;
    logic [XLEN-1:0]  w_skid_imm_next;
    logic [TAG_W-1:0] w_skid_tag_next;
    logic             w_skid_ill_next;

    logic             w_in_xfer;
    logic             w_out_xfer;

    // Low word is formed at 32 bits; w_sext says whether bit 31 is a sign bit.
    always_comb begin
        w_imm32 = '0;
        w_sext  = 1'b1;
        w_ill   = 1'b0;
        unique case (bus.immsrc_i)
            SRC_I: w_imm32 = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
            SRC_S: w_imm32 = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
            SRC_B: w_imm32 = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                              bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
            SRC_J: w_imm32 = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                              bus.instr_i[20], bus.instr_i[30:21], 1'b0};
            SRC_U: w_imm32 = {bus.instr_i[31:12], 12'b0};
            SRC_Z: begin
                w_imm32 = {27'b0, bus.instr_i[19:15]};
                w_sext  = 1'b0;
            end
            SRC_SHAMT: begin
                if (XLEN == 64) begin
                    w_imm32 = {26'b0, bus.instr_i[25:20]};
                end else begin
                    w_imm32 = {27'b0, bus.instr_i[24:20]};
                end
                w_sext = 1'b0;
            end
            default: begin
                w_imm32 = '0;
                w_sext  = 1'b0;
                w_ill   = 1'b1;
            end
        endcase
    end

    assign w_imm[31:0] = w_imm32;

    genvar gi;
    generate
        for (gi = 32; gi < XLEN; gi++) begin : g_upper
            assign w_imm[gi] = w_sext & w_imm32[31];
        end
    endgenerate

    assign w_in_xfer  = bus.valid_i && r_ready;
    assign w_out_xfer = r_out_valid && bus.ready_i;

    always_comb begin
        w_out_valid_next  = r_out_valid;
        w_out_imm_next    = r_out_imm;
        w_out_tag_next    = r_out_tag;
        w_out_ill_next    = r_out_ill;
        w_skid_valid_next = r_skid_valid;
        w_skid_imm_next   = r_skid_imm;
        w_skid_tag_next   = r_skid_tag;
        w_skid_ill_next   = r_skid_ill;

        if (bus.flush_i) begin
            w_out_valid_next  = 1'b0;
            w_skid_valid_next = 1'b0;
        end else if (!r_out_valid || w_out_xfer) begin
            if (r_skid_valid) begin
                // Skid beat is older than anything arriving now, so it goes first.
                w_out_valid_next  = 1'b1;
                w_out_imm_next    = r_skid_imm;
                w_out_tag_next    = r_skid_tag;
                w_out_ill_next    = r_skid_ill;
                w_skid_valid_next = w_in_xfer;
                if (w_in_xfer) begin
                    w_skid_imm_next = w_imm;
                    w_skid_tag_next = bus.tag_i;
                    w_skid_ill_next = w_ill;
                end
            end else if (w_in_xfer) begin
                w_out_valid_next = 1'b1;
                w_out_imm_next   = w_imm;
                w_out_tag_next   = bus.tag_i;
                w_out_ill_next   = w_ill;
            end else begin
                w_out_valid_next = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_valid_next = 1'b1;
            w_skid_imm_next   = w_imm;
            w_skid_tag_next   = bus.tag_i;
            w_skid_ill_next   = w_ill;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_tag    <= '0;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_ill   <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_next;
            r_out_imm    <= w_out_imm_next;
            r_out_tag    <= w_out_tag_next;
            r_out_ill    <= w_out_ill_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_imm   <= w_skid_imm_next;
            r_skid_tag   <= w_skid_tag_next;
            r_skid_ill   <= w_skid_ill_next;
            r_ready      <= !w_skid_valid_next;
        end
    end

    assign bus.ready_o   = r_ready;
    assign bus.valid_o   = r_out_valid;
    assign bus.immext_o  = r_out_imm;
    assign bus.tag_o     = r_out_tag;
    assign bus.illegal_o = r_out_ill;

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
Parametrised, pipelined successor to the decode-stage immediate extender. It adds U, CSR-uimm and shift-amount formats and an illegal-format flag. The output width is selectable (XLEN 32/64), with a valid/ready handshake and a 2-entry skid buffer so decode-to-execute runs at full throughput under backpressure. It sits between the instruction register and the ID/EX boundary, and carries a sideband tag (PC/rd) alongside the immediate.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag carried with each immediate.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_n_i  input  1  asynchronous, active-low reset.
instr_i  input  25 [31:7]  instruction bits above the opcode.
immsrc_i  input  3  immediate format select.
tag_i  input  TAG_W  sideband tag, travels with the beat.
valid_i  input  1  input beat valid.
ready_o  output  1  block can accept a beat.
flush_i  input  1  synchronous pipeline flush.
immext_o  output  XLEN  extended immediate.
tag_o  output  TAG_W  tag of the output beat.
illegal_o  output  1  output beat used a reserved immsrc.
valid_o  output  1  output beat valid.
ready_i  input  1  downstream accepts the beat.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: valid_o=0, immext_o=0, tag_o=0, illegal_o=0, ready_o=1, skid entry empty. Reset asserted mid-transfer discards all held beats immediately.
- Formats (s = sign-extend to XLEN from instr_i[31]; z = zero-extend):
  - 000 I: s{instr[31:20]}
  - 001 S: s{instr[31:25],instr[11:7]}
  - 010 B: s{instr[31],instr[7],instr[30:25],instr[11:8],0}
  - 011 J: s{instr[31],instr[19:12],instr[20],instr[30:21],0}
  - 100 U: s{instr[31:12],12'b0}; with XLEN=64, bits 63:32 replicate bit 31.
  - 101 Z (CSR uimm): z{instr[19:15]}
  - 110 SHAMT: z{instr[24:20]} when XLEN=32; z{instr[25:20]} when XLEN=64.
  - 111 reserved: immext=0, illegal=1.
  - For all other codes, illegal=0.
- Extension: computed combinationally on input; result, tag and illegal are registered together as one beat.
- Handshake:
  - An input transfer occurs when valid_i && ready_o.
  - An output transfer occurs when valid_o && ready_i.
  - Latency is exactly 1 cycle from input transfer to valid_o when the output stage is empty.
- Output stage:
  - Loads the incoming beat when empty or transferring this cycle.
  - Otherwise the incoming beat goes to the skid entry.
  - On an output transfer with the skid entry full, the skid beat moves to the output stage. If a new input transfers in the same cycle, it enters the skid entry; no beat is lost or reordered.
- ready_o: registered; equals "skid entry empty". It must not depend combinationally on ready_i.
- Stall: while valid_o && !ready_i, immext_o, tag_o and illegal_o stay stable.
- Ordering: beats leave in strict arrival order.
- flush_i (synchronous):
  - Next cycle valid_o=0, skid empty, ready_o=1.
  - Any input beat presented in the flush cycle is dropped.
  - Any output transfer in the flush cycle still counts downstream.
  - Data registers may retain stale values, but valid_o=0.
- Simultaneous flush_i and full skid: flush wins.
- Steady state with ready_i=1: throughput of one beat per cycle.

Test Plan:
- I-type, XLEN=32: instr_i=0x1FFE001 (from 0xFFF00093, addi x1,x0,-1), immsrc=000, valid 1 cycle, ready_i=1 -> next cycle valid_o=1, immext_o=0xFFFFFFFF, illegal_o=0.
- B-type: instr 0xFE000EE3 (beq -4) -> instr_i=0x1FC001D, immsrc=010 -> immext_o=0xFFFFFFFC. U-type with XLEN=64: instr 0x800000B7 -> immext_o=0xFFFFFFFF80000000.
- Backpressure: ready_i=0; send beats A(tag 1), B(tag 2), C(tag 3) back-to-back -> A held on output; ready_o=0 after B accepted; C not accepted until space frees. Then ready_i=1 -> outputs A, B, C in order on consecutive cycles; no beat duplicated.
- Flush with both entries full plus a new valid_i in the same cycle -> next cycle valid_o=0, ready_o=1; the new beat is never output.
- immsrc=111 with any instr -> immext_o=0, illegal_o=1. immsrc=110, instr[25:20]=6'b100011 -> 0x23 with XLEN=64, 0x03 with XLEN=32.
- Assert rst_n_i asynchronously mid-stall (between clock edges) -> valid_o and immext_o go to 0 before the next edge, and ready_o=1.
